onewire_master: RTL and testbench



---
 rtl/onewire_pkg.sv | 27 ++
 rtl/onewire_us_tick.sv | 31 +++
 rtl/onewire_master.sv | 164 ++++++++++++++++
 tb/tb_onewire_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onewire_pkg
// Purpose  : Shared types and constants for the 1-Wire bus master.
// Revision : 1.0
// ============================================================================
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_REL  = 3'd2,
        ST_SLOT_LOW = 3'd3,
        ST_SLOT_REL = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;

    localparam int T_LOW1_US   = 6;
    localparam int T_SAMPLE_US = 15;
    localparam int T_LOW0_US   = 60;

endpackage
`default_nettype wire

// File: rtl/onewire_us_tick.sv
`default_nettype none
// ============================================================================
// Module   : onewire_us_tick
// Purpose  : Prescaler giving a 1-cycle pulse every DIV clocks; restartable.
// Revision : 1.0
// ============================================================================
module onewire_us_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i || (cnt_q == c_last)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/onewire_master.sv
`default_nettype none
// ============================================================================
// Module   : onewire_master
// Purpose  : Avalon-MM 1-Wire master: reset/presence and byte-wide slots.
// Revision : 1.0
// ============================================================================
module onewire_master
    import onewire_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int T_RESET_US  = 480,
    parameter int T_PRES_US   = 70,
    parameter int T_SLOT_US   = 70
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    inout  wire         onewire_io
);
    localparam int C_DIV = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
    localparam int CW    = 16;

    // Counter compare points: the counter holds whole microseconds since state entry.
    localparam logic [CW-1:0] c_rst_end   = CW'(T_RESET_US - 1);
    localparam logic [CW-1:0] c_pres_pt   = CW'(T_PRES_US - 1);
    localparam logic [CW-1:0] c_low1_end  = CW'(T_LOW1_US - 1);
    localparam logic [CW-1:0] c_low0_end  = CW'(T_LOW0_US - 1);
    localparam logic [CW-1:0] c_sample_pt = CW'(T_SAMPLE_US - T_LOW1_US - 1);
    localparam logic [CW-1:0] c_rel1_end  = CW'(T_SLOT_US - T_LOW1_US - 1);
    localparam logic [CW-1:0] c_rel0_end  = CW'(T_SLOT_US - T_LOW0_US - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   us_cnt_q, us_cnt_d;
    logic [7:0]      tx_q, tx_d, rx_q, rx_d;
    logic [2:0]      bit_q, bit_d;
    logic            done_q, done_d, pres_q, pres_d, irq_en_q, irq_en_d;
    logic            sync0_q, sync1_q;
    logic [31:0]     rdata_d;
    logic            w_wr, w_tick, w_restart, w_busy, w_tx_bit, w_drive_low;
    logic            w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_tx_bit = tx_q[bit_q];
    assign w_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign w_unused = ^writedata[31:8];

    onewire_us_tick #(.DIV(C_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (w_restart),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        done_d   = done_q;
        pres_d   = pres_q;
        irq_en_d = irq_en_q;
        if (w_wr && address == ADDR_CTRL)   irq_en_d = writedata[1];
        if (w_wr && address == ADDR_STATUS) done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_wr && address == ADDR_DATA) begin
                    state_d = ST_SLOT_LOW;
                    tx_d    = writedata[7:0];
                    rx_d    = 8'h00;
                    bit_d   = 3'd0;
                    done_d  = 1'b0;
                end else if (w_wr && address == ADDR_CTRL && writedata[0]) begin
                    state_d = ST_RST_LOW;
                    done_d  = 1'b0;
                end
            end
            ST_RST_LOW: begin
                if (w_tick && us_cnt_q == c_rst_end) state_d = ST_RST_REL;
            end
            ST_RST_REL: begin
                if (w_tick) begin
                    if (us_cnt_q == c_pres_pt) pres_d  = ~sync1_q;
                    if (us_cnt_q == c_rst_end) state_d = ST_DONE;
                end
            end
            ST_SLOT_LOW: begin
                if (w_tick && us_cnt_q == (w_tx_bit ? c_low1_end : c_low0_end))
                    state_d = ST_SLOT_REL;
            end
            ST_SLOT_REL: begin
                // Only a written 1 releases early enough for a slave to answer.
                if (w_tick) begin
                    if (w_tx_bit && us_cnt_q == c_sample_pt) rx_d[bit_q] = sync1_q;
                    if (us_cnt_q == (w_tx_bit ? c_rel1_end : c_rel0_end)) begin
                        if (bit_q == 3'd7) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            state_d = ST_SLOT_LOW;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_restart = (state_d != state_q);
    assign us_cnt_d  = w_restart ? '0 : (w_tick ? us_cnt_q + CW'(1) : us_cnt_q);

    always_comb begin
        rdata_d = 32'h0;
        case (address)
            ADDR_DATA:   rdata_d = {24'h0, rx_q};
            ADDR_CTRL:   rdata_d = {30'h0, irq_en_q, 1'b0};
            ADDR_STATUS: rdata_d = {29'h0, pres_q, done_q, w_busy};
            default:     rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            us_cnt_q <= '0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            bit_q    <= 3'd0;
            done_q   <= 1'b0;
            pres_q   <= 1'b0;
            irq_en_q <= 1'b0;
            sync0_q  <= 1'b1;
            sync1_q  <= 1'b1;
            readdata <= 32'h0;
        end else begin
            state_q  <= state_d;
            us_cnt_q <= us_cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
            pres_q   <= pres_d;
            irq_en_q <= irq_en_d;
            sync0_q  <= onewire_io;
            sync1_q  <= sync0_q;
            readdata <= rdata_d;
        end
    end

    // Drive comes straight from the state register so reset releases the line at once.
    assign w_drive_low = (state_q == ST_RST_LOW) || (state_q == ST_SLOT_LOW);
    assign onewire_io  = w_drive_low ? 1'b0 : 1'bz;
    assign irq         = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_onewire_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_onewire_master
// Purpose  : Self-checking bench with a 1-Wire slave model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int US = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        irq;
    wire         owb;
    logic        slave_low = 1'b0;

    pullup (owb);
    assign owb = slave_low ? 1'b0 : 1'bz;

    onewire_master #(
        .CLK_FREQ_HZ (4000000),
        .T_RESET_US  (480),
        .T_PRES_US   (70),
        .T_SLOT_US   (70)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .onewire_io (owb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         exp_low[$];
    int         exp_per[$];
    logic [7:0] exp_rx[$];

    // Slave model / bus monitor, evaluated once per cycle on the falling clock edge.
    int         cyc = 0, fall_t = 0, last_fall = -1, nfall = 0;
    int         sl_until = 0, pres_from = 0, pres_to = 0, ret_idx = 0;
    logic       prev_b = 1'b1, b_now, m_pulse = 1'b0, touched = 1'b0;
    logic       pres_en = 1'b1, ret_en = 1'b0;
    logic [7:0] ret_byte = 8'hFF;

    always @(negedge clk) begin
        cyc++;
        b_now = owb;
        if (slave_low) touched = 1'b1;
        if (prev_b && !b_now && !slave_low) begin
            if (last_fall >= 0 && exp_per.size() > 0)
                check_eq("slot_period", 32'(cyc - last_fall), 32'(exp_per.pop_front()));
            last_fall = cyc;
            fall_t    = cyc;
            m_pulse   = 1'b1;
            touched   = 1'b0;
            nfall++;
            if (ret_en) begin
                if (!ret_byte[ret_idx[2:0]]) sl_until = cyc + 40 * US;
                ret_idx++;
            end
        end else if (!prev_b && b_now && m_pulse) begin
            m_pulse = 1'b0;
            if (!touched && exp_low.size() > 0)
                check_eq("low_width", 32'(cyc - fall_t), 32'(exp_low.pop_front()));
            // Presence pulse starts inside the 15-60 us window and lasts 120 us.
            if (pres_en && (cyc - fall_t) >= 400 * US) begin
                pres_from = cyc + 30 * US;
                pres_to   = cyc + 150 * US;
            end
        end
        prev_b    = b_now;
        slave_low = (cyc < sl_until) || (cyc >= pres_from && cyc < pres_to);
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < 3000 * US && !s[1]; i++) bus_read(ADDR_STATUS, s);
        if (!s[1]) check_eq(tag, 32'(s[1]), 32'd1);
    endtask

    task automatic start_byte(input logic [7:0] tx, input logic [7:0] ret, input logic timing);
        ret_byte = ret; ret_idx = 0; ret_en = 1'b1; nfall = 0; last_fall = -1;
        if (timing) begin
            for (int k = 0; k < 8; k++) begin
                exp_low.push_back((tx[k] ? 6 : 60) * US);
                if (k > 0) exp_per.push_back(70 * US);
            end
        end
        exp_rx.push_back(tx & ret);
        bus_write(ADDR_DATA, {24'h0, tx});
    endtask

    task automatic finish_byte(input string tag);
        logic [31:0] d;
        wait_done({tag, "_timeout"});
        bus_read(ADDR_DATA, d);
        if (exp_rx.size() > 0) check_eq({tag, "_rx"}, d, {24'h0, exp_rx.pop_front()});
    endtask

    initial begin
        logic [31:0] d;
        int t;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus_read(ADDR_DATA, d);   check_eq("rst_data", d, 32'h0);
        bus_read(ADDR_CTRL, d);   check_eq("rst_ctrl", d, 32'h0);
        bus_read(ADDR_STATUS, d); check_eq("rst_status", d, 32'h0);
        check_eq("rst_bus", 32'(owb), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);

        // Reset / presence sequence with interrupt enabled
        exp_low.push_back(480 * US);
        bus_write(ADDR_CTRL, 32'h3);
        repeat (100 * US) @(negedge clk);
        check_eq("rstseq_drive", 32'(owb), 32'd0);
        bus_read(ADDR_STATUS, d); check_eq("rstseq_busy", d, 32'h1);
        wait_done("rstseq_timeout");
        bus_read(ADDR_STATUS, d); check_eq("rstseq_status", d, 32'h6);
        check_eq("rstseq_irq", 32'(irq), 32'd1);
        bus_read(ADDR_CTRL, d);   check_eq("ctrl_readback", d, 32'h2);
        check_eq("rstseq_width_seen", 32'(exp_low.size()), 32'd0);
        bus_write(ADDR_STATUS, 32'h0);
        bus_read(ADDR_STATUS, d); check_eq("done_clear", d, 32'h4);
        check_eq("irq_clear", 32'(irq), 32'd0);

        // Write 0xA5: slot widths and periods
        start_byte(8'hA5, 8'hFF, 1'b1);
        finish_byte("wr_a5");
        bus_read(ADDR_STATUS, d); check_eq("a5_status", d, 32'h6);
        check_eq("a5_slots", 32'(nfall), 32'd8);
        check_eq("a5_widths_seen", 32'(exp_low.size()), 32'd0);
        check_eq("a5_periods_seen", 32'(exp_per.size()), 32'd0);

        // Read byte: slave answers 0x3C
        start_byte(8'hFF, 8'h3C, 1'b0);
        finish_byte("rd_3c");

        // Write while busy is ignored
        start_byte(8'hFF, 8'h96, 1'b0);
        repeat (300 * US) @(negedge clk);
        bus_write(ADDR_DATA, 32'h12);
        bus_read(ADDR_STATUS, d); check_eq("busy_mid", d & 32'h3, 32'h1);
        finish_byte("rd_96");
        repeat (100 * US) @(negedge clk);
        check_eq("ignored_slots", 32'(nfall), 32'd8);
        bus_read(ADDR_STATUS, d); check_eq("ignored_status", d, 32'h6);

        // Reset during slot 3
        start_byte(8'hFF, 8'hFF, 1'b0);
        t = 0;
        while (nfall < 4 && t < 2000 * US) begin
            @(negedge clk);
            t++;
        end
        check_eq("slot3_reached", 32'(nfall), 32'd4);
        repeat (3) @(negedge clk);
        check_eq("slot3_low", 32'(owb), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_bus", 32'(owb), 32'd1);
        reset = 1'b0;
        void'(exp_rx.pop_back());
        bus_read(ADDR_STATUS, d); check_eq("mid_reset_status", d, 32'h0);
        bus_read(ADDR_DATA, d);   check_eq("mid_reset_rx", d, 32'h0);
        bus_read(ADDR_CTRL, d);   check_eq("mid_reset_ctrl", d, 32'h0);
        check_eq("mid_reset_irq", 32'(irq), 32'd0);

        // Transfer after reset completes normally
        start_byte(8'hFF, 8'h5A, 1'b0);
        finish_byte("rd_5a");
        bus_read(ADDR_STATUS, d); check_eq("post_reset_status", d, 32'h2);
        check_eq("rx_queue_empty", 32'(exp_rx.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
